// File: rtl/board_pkg.sv
// Shared board sprite definitions: FSM state encoding and sprite geometry used by the ROMs.
package board_pkg;

    typedef enum logic [1:0] {
        HOME      = 2'd0,
        MOVE_DOWN = 2'd1,
        AT_END    = 2'd2,
        MOVE_UP   = 2'd3
    } board_state_t;

    localparam int BOARD_W      = 68;
    localparam int BOARD_H      = 12;
    localparam int BOARD_ADDR_W = 10;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain and emits one pulse per rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= frame_clk;
            sync <= meta;
            prev <= sync;
        end
    end

    // A level held high for many cycles still yields a single tick.
    assign tick = sync & ~prev;

endmodule

// File: rtl/board_motion_ctrl.sv
// Moving platform sequencer: steps board_y one frame at a time and drives the sprite pixel lookup.
//
//  state     | meaning
//  ----------+-------------------------------------------------
//  HOME      | resting at Y_HOME, waiting for activate=1
//  MOVE_DOWN | stepping toward Y_END each tick
//  AT_END    | resting at Y_END, waiting for activate=0
//  MOVE_UP   | stepping toward Y_HOME each tick
module board_motion_ctrl
    import board_pkg::*;
#(
    parameter int X0     = 556,
    parameter int W      = BOARD_W,
    parameter int H      = BOARD_H,
    parameter int Y_HOME = 204,
    parameter int Y_END  = 252,
    parameter int STEP   = 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_clk,
    input  logic                    activate,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    output logic [9:0]              board_y,
    output logic                    moving,
    output logic                    at_end,
    output logic                    is_board,
    output logic [BOARD_ADDR_W-1:0] board_address
);

    localparam logic [10:0] Y_HOME11 = 11'(Y_HOME);
    localparam logic [10:0] Y_END11  = 11'(Y_END);
    localparam logic [10:0] STEP11   = 11'(STEP);
    localparam logic [10:0] X_LO     = 11'(X0);
    localparam logic [10:0] X_HI     = 11'(X0 + W);

    board_state_t state;
    logic         tick;
    logic [10:0]  y_dn;
    logic [10:0]  y_up;

    frame_tick_sync u_tick (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .frame_clk(frame_clk),
        .tick     (tick)
    );

    // 11-bit arithmetic keeps the clamp comparisons free of wrap-around.
    assign y_dn = {1'b0, board_y} + STEP11;
    assign y_up = {1'b0, board_y} - STEP11;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= HOME;
            board_y <= 10'(Y_HOME);
            moving  <= 1'b0;
            at_end  <= 1'b0;
        end else if (tick) begin
            unique case (state)
                HOME: begin
                    if (activate) begin
                        state  <= MOVE_DOWN;
                        moving <= 1'b1;
                    end
                end
                MOVE_DOWN: begin
                    if (!activate) begin
                        state <= MOVE_UP;
                    end else if (y_dn >= Y_END11) begin
                        board_y <= 10'(Y_END);
                        state   <= AT_END;
                        moving  <= 1'b0;
                        at_end  <= 1'b1;
                    end else begin
                        board_y <= y_dn[9:0];
                    end
                end
                AT_END: begin
                    if (!activate) begin
                        state  <= MOVE_UP;
                        moving <= 1'b1;
                        at_end <= 1'b0;
                    end
                end
                MOVE_UP: begin
                    if (activate) begin
                        state <= MOVE_DOWN;
                    end else if ({1'b0, board_y} <= Y_HOME11 + STEP11) begin
                        board_y <= 10'(Y_HOME);
                        state   <= HOME;
                        moving  <= 1'b0;
                    end else begin
                        board_y <= y_up[9:0];
                    end
                end
                default: begin
                    state   <= HOME;
                    board_y <= 10'(Y_HOME);
                    moving  <= 1'b0;
                    at_end  <= 1'b0;
                end
            endcase
        end
    end

    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] top;
    logic [10:0] bot;
    logic        hit;
    logic [9:0]  col;
    logic [9:0]  row;

    assign px  = {1'b0, DrawX};
    assign py  = {1'b0, DrawY};
    assign top = {1'b0, board_y};
    assign bot = top + 11'(H);
    assign hit = (px >= X_LO) && (px < X_HI) && (py >= top) && (py < bot);
    assign col = DrawX - 10'(X0);
    assign row = DrawY - board_y;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            is_board      <= 1'b0;
            board_address <= '0;
        end else begin
            is_board      <= hit;
            board_address <= hit ? (col + row * 10'(W)) : '0;
        end
    end

endmodule
